// File: rtl/arm_pkg.sv
// Shared constants for the ARM memory-stage SRAM controller: FSM encoding and default address map.
package arm_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD_LO = 3'd1;
    localparam logic [2:0] RD_HI = 3'd2;
    localparam logic [2:0] WR_LO = 3'd3;
    localparam logic [2:0] WR_HI = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam int unsigned BASE_ADDR_DEF = 1024;

endpackage

// File: rtl/sram_phase_cnt.sv
// Phase counter: counts 0..LAST while enabled, then wraps; clr forces zero.
// Latency: tc is combinational from the count register; cnt_nxt exposes the next count.
// Backpressure: none, free-running under en.
module sram_phase_cnt #(
    parameter int unsigned LAST = 1,
    parameter int          CW   = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] cnt_nxt,
    output logic          tc
);

    assign tc = (cnt == CW'(LAST));

    always_comb begin
        cnt_nxt = cnt;
        if (clr || tc)
            cnt_nxt = '0;
        else if (en)
            cnt_nxt = cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end

endmodule

// File: rtl/sram_ctrl.sv
// Sequences one 32-bit MEM-stage load/store as two 16-bit halves on an async SRAM.
// Latency: 2*(WAIT_CYCLES+1)+1 cycles from request seen in IDLE to ready=1 (DONE).
// Backpressure: ready=0 stalls the pipeline; the request is held by the stage register.
module sram_ctrl
    import arm_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int          SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    localparam int          CW   = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [31:0] BASE = 32'(BASE_ADDR);

    if (WAIT_CYCLES < 1) begin : g_wait_check
        $error("sram_ctrl: WAIT_CYCLES must be >= 1 or the write strobe never asserts");
    end

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          tc, busy, wr_nxt;
    logic [15:0]   wdata_hi_q;
    logic [31:0]   off;
    logic          unused_off;

    // Offset bits beyond the SRAM range are dropped on purpose, no range check.
    assign off        = addr - BASE;
    assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};

    assign busy   = (state_q == RD_LO) || (state_q == RD_HI) ||
                    (state_q == WR_LO) || (state_q == WR_HI);
    assign wr_nxt = (state_d == WR_LO) || (state_d == WR_HI);
    assign ready  = (state_q == DONE) ||
                    ((state_q == IDLE) && !mem_r_en && !mem_w_en);

    sram_phase_cnt #(.LAST(WAIT_CYCLES), .CW(CW)) u_phase (
        .clk     (clk),
        .rst     (rst),
        .en      (busy),
        .clr     (!busy),
        .cnt     (cnt),
        .cnt_nxt (cnt_nxt),
        .tc      (tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_w_en) state_d = WR_LO;
                     else if (mem_r_en) state_d = RD_LO;
            RD_LO:   if (tc) state_d = RD_HI;
            RD_HI:   if (tc) state_d = DONE;
            WR_LO:   if (tc) state_d = WR_HI;
            WR_HI:   if (tc) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pins are registered from next-state so they line up with the state they belong to;
    // the strobe releases on the last phase cycle so address/data hold past its rising edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            rdata       <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            wdata_hi_q  <= '0;
        end else begin
            state_q    <= state_d;
            sram_dq_oe <= wr_nxt;
            sram_we_n  <= !(wr_nxt && (cnt_nxt != CW'(WAIT_CYCLES)));
            if ((state_q == IDLE) && (state_d != IDLE)) begin
                sram_addr <= {off[SRAM_AW:2], 1'b0};
                if (state_d == WR_LO) begin
                    sram_dq_out <= wdata[15:0];
                    wdata_hi_q  <= wdata[31:16];
                end
            end
            if (tc && ((state_q == RD_LO) || (state_q == WR_LO)))
                sram_addr[0] <= 1'b1;
            if (tc && (state_q == WR_LO))
                sram_dq_out <= wdata_hi_q;
            if (tc && (state_q == RD_LO))
                rdata[15:0] <= sram_dq_in;
            if (tc && (state_q == RD_HI))
                rdata[31:16] <= sram_dq_in;
        end
    end

endmodule
